// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time loader. Parses a 16-bit word-count header from a
//                byte stream, assembles little-endian words and writes them
//                into instruction memory while holding the CPU in reset.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             we,
    output logic [WIDTH-1:0] waddr,
    output logic [WIDTH-1:0] wdata,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);

    localparam int          IW      = $clog2(DEPTH + 1);
    localparam logic [15:0] c_depth = 16'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_LO = 3'd1,
        S_HDR_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t          r_state;
    logic [15:0]     r_count;
    logic [IW-1:0]   r_word_idx;
    logic [1:0]      r_byte_cnt;
    logic [23:0]     r_asm;
    logic            r_armed;

    logic            w_xfer;
    logic            w_start;
    logic [15:0]     w_count_full;
    logic [IW-1:0]   w_idx_next;
    logic [WIDTH-1:0] w_waddr;

    assign w_xfer       = byte_valid && byte_ready;
    // A start seen on the first edge after reset release is not honoured.
    assign w_start      = start && r_armed;
    assign w_count_full = {byte_in, r_count[7:0]};
    assign w_idx_next   = r_word_idx + 1'b1;
    assign w_waddr      = WIDTH'(r_word_idx) << 2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= 16'd0;
            r_word_idx <= '0;
            r_byte_cnt <= 2'd0;
            r_asm      <= 24'd0;
            r_armed    <= 1'b0;
            byte_ready <= 1'b0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            we      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_word_idx <= '0;
                    r_byte_cnt <= 2'd0;
                    done       <= 1'b0;
                    error      <= 1'b0;
                    cpu_hold   <= 1'b1;
                    if (w_start) begin
                        r_state    <= S_HDR_LO;
                        byte_ready <= 1'b1;
                    end
                end
                S_HDR_LO: begin
                    if (w_xfer) begin
                        r_count[7:0] <= byte_in;
                        r_state      <= S_HDR_HI;
                    end
                end
                S_HDR_HI: begin
                    if (w_xfer) begin
                        r_count <= w_count_full;
                        if ((w_count_full == 16'd0) || (w_count_full > c_depth)) begin
                            r_state    <= S_ERR;
                            error      <= 1'b1;
                            byte_ready <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        if (r_byte_cnt == 2'd3) begin
                            we         <= 1'b1;
                            wdata      <= WIDTH'({byte_in, r_asm});
                            waddr      <= w_waddr;
                            byte_ready <= 1'b0;
                            r_state    <= S_WRITE;
                        end else begin
                            r_asm      <= {byte_in, r_asm[23:8]};
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    r_word_idx <= w_idx_next;
                    r_byte_cnt <= 2'd0;
                    if (16'(w_idx_next) == r_count) begin
                        r_state  <= S_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        r_state    <= S_DATA;
                        byte_ready <= 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    if (w_start) begin
                        r_state    <= S_HDR_LO;
                        byte_ready <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        r_word_idx <= '0;
                        r_byte_cnt <= 2'd0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader with a
//                stream-level model of the expected memory writes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       byte_in = 8'd0;
    logic             byte_valid = 1'b0;
    logic             byte_ready;
    logic             we;
    logic [WIDTH-1:0] waddr;
    logic [WIDTH-1:0] wdata;
    logic             cpu_hold;
    logic             done;
    logic             error;

    imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_writes = 0;
    int          w_base;
    logic [31:0] last_waddr = 32'd0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    bit          exp_error;

    logic [7:0]  s3[$]  = '{8'h03, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                            8'h93, 8'h00, 8'hA0, 8'h00, 8'h33, 8'h81, 8'h20, 8'h00};
    logic [7:0]  s1[$]  = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0]  s0[$]  = '{8'h00, 8'h00};
    logic [7:0]  s65[$] = '{8'h41, 8'h00};
    logic [7:0]  s64[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Stream-level reference: header decides legality, then every 4 bytes form one word.
    task automatic model_load(input logic [7:0] s[$]);
        int cnt;
        cnt = int'(s[0]) + 256 * int'(s[1]);
        exp_error = (cnt == 0) || (cnt > DEPTH);
        if (!exp_error) begin
            for (int w = 0; w < cnt; w++) begin
                exp_addr_q.push_back(32'(w * 4));
                exp_data_q.push_back({s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]});
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && we === 1'b1) begin
            n_writes++;
            last_waddr = waddr;
            check("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
            if (exp_addr_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_we: waddr %h wdata %h, expected no write", waddr, wdata);
            end else begin
                check("waddr", waddr, exp_addr_q.pop_front());
                check("wdata", wdata, exp_data_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stall);
        bit got;
        int guard;
        got   = 1'b0;
        guard = 0;
        while (!got) begin
            @(negedge clk);
            if (stall && $urandom_range(0, 2) == 0) begin
                byte_valid = 1'b0;
                byte_in    = 8'($urandom);
            end else begin
                byte_valid = 1'b1;
                byte_in    = b;
                got        = byte_ready;
            end
            @(posedge clk);
            guard++;
            if (!got && guard > 100) begin
                n_cmp++;
                n_err++;
                $display("FAIL byte_timeout: byte %h not accepted, expected acceptance", b);
                got = 1'b1;
            end
        end
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit stall);
        foreach (s[i]) send_byte(s[i], stall);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
        check({tag, "_we"},    {31'd0, we},         32'd0);
        check({tag, "_waddr"}, waddr,               32'd0);
        check({tag, "_wdata"}, wdata,               32'd0);
        check({tag, "_hold"},  {31'd0, cpu_hold},   32'd1);
        check({tag, "_done"},  {31'd0, done},       32'd0);
        check({tag, "_error"}, {31'd0, error},      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int w = 0; w < 64; w++) begin
            s64.push_back(8'(w));
            s64.push_back(8'h00);
            s64.push_back(8'hDE);
            s64.push_back(8'hC0);
        end
        s64.push_front(8'h00);
        s64.push_front(8'h40);

        #12;
        check_reset("por");

        // start on the release cycle must be ignored
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_at_release_ready", {31'd0, byte_ready}, 32'd0);
        check("start_at_release_hold", {31'd0, cpu_hold}, 32'd1);

        // three-word load, no stalls
        model_load(s3);
        check("model_w0", exp_data_q[0], 32'h00500013);
        check("model_w1", exp_data_q[1], 32'h00A00093);
        check("model_w2", exp_data_q[2], 32'h00208133);
        check("model_a2", exp_addr_q[2], 32'd8);
        w_base = n_writes;
        pulse_start();
        check("load3_ready", {31'd0, byte_ready}, 32'd1);
        foreach (s3[i]) send_byte(s3[i], 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        check("load3_last_we", {31'd0, we}, 32'd1);
        check("load3_done_not_yet", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("load3_done", {31'd0, done}, 32'd1);
        check("load3_hold", {31'd0, cpu_hold}, 32'd0);
        check("load3_nwrites", 32'(n_writes - w_base), 32'd3);
        check("load3_queue", 32'(exp_addr_q.size()), 32'd0);

        // reload from DONE with a start pulse inside DATA
        pulse_start();
        check("reload_hold", {31'd0, cpu_hold}, 32'd1);
        check("reload_done_clr", {31'd0, done}, 32'd0);
        model_load(s1);
        w_base = n_writes;
        for (int i = 0; i < 4; i++) send_byte(s1[i], 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("data_start_ignored", {31'd0, byte_ready}, 32'd1);
        send_byte(s1[4], 1'b0);
        send_byte(s1[5], 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        @(negedge clk);
        check("reload_done", {31'd0, done}, 32'd1);
        check("reload_last_waddr", last_waddr, 32'd0);
        check("reload_nwrites", 32'(n_writes - w_base), 32'd1);

        // zero count header
        pulse_start();
        model_load(s0);
        check("model_zero_err", {31'd0, exp_error}, 32'd1);
        w_base = n_writes;
        send_stream(s0, 1'b0);
        check("zero_error", {31'd0, error}, 32'd1);
        check("zero_hold", {31'd0, cpu_hold}, 32'd1);
        check("zero_ready", {31'd0, byte_ready}, 32'd0);
        check("zero_done", {31'd0, done}, 32'd0);

        // over-capacity header
        pulse_start();
        check("err_cleared", {31'd0, error}, 32'd0);
        model_load(s65);
        send_stream(s65, 1'b0);
        check("over_error", {31'd0, error}, 32'd1);
        check("bad_hdr_nwrites", 32'(n_writes - w_base), 32'd0);

        // full-capacity load
        pulse_start();
        model_load(s64);
        w_base = n_writes;
        send_stream(s64, 1'b0);
        @(negedge clk);
        check("full_done", {31'd0, done}, 32'd1);
        check("full_error", {31'd0, error}, 32'd0);
        check("full_last_waddr", last_waddr, 32'd252);
        check("full_nwrites", 32'(n_writes - w_base), 32'd64);

        // three-word load with random byte_valid stalls
        pulse_start();
        model_load(s3);
        w_base = n_writes;
        send_stream(s3, 1'b1);
        @(negedge clk);
        check("stall_done", {31'd0, done}, 32'd1);
        check("stall_nwrites", 32'(n_writes - w_base), 32'd3);
        check("stall_queue", 32'(exp_addr_q.size()), 32'd0);

        // asynchronous reset in the middle of a word
        pulse_start();
        w_base = n_writes;
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_nwrites", 32'(n_writes - w_base), 32'd0);
        check("mid_idle_ready", {31'd0, byte_ready}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle core's instruction memory. It accepts a byte stream over a valid/ready handshake, parses a 16-bit word-count header, assembles little-endian 32-bit instruction words and issues one write per word into instruction memory. It holds the CPU in reset until the load completes, and reports done or error status. It sits between the external program source (UART receiver or testbench) and the instruction memory write port.

## Interface
- `WIDTH`, default 32: instruction/address width; words written are `WIDTH` bits.
- `DEPTH`, default 64: instruction memory capacity in words; maximum legal word count.
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  reset; **one clock; reset is asynchronous and active-low**.
- `start`  input  1  single-cycle pulse; begins a load session.
- `byte_in`  input  8  stream data byte.
- `byte_valid`  input  1  `byte_in` valid.
- `byte_ready`  output  1  loader can accept a byte.
- `we`  output  1  instruction memory write enable, one cycle per word.
- `waddr`  output  WIDTH  byte address of the word being written (word index × 4).
- `wdata`  output  WIDTH  instruction word being written.
- `cpu_hold`  output  1  keeps the core/PC in reset while high.
- `done`  output  1  load finished successfully (level).
- `error`  output  1  header rejected (level).

## Operation
- A byte transfer occurs on a rising edge when `byte_valid && byte_ready`. No other cycle consumes a byte.
- FSM states: IDLE, HDR_LO, HDR_HI, DATA, WRITE, DONE, ERR.
- **IDLE**
  - `start` → HDR_LO.
  - Clears the word counter, byte counter, `done` and `error`.
- **HDR_LO**
  - On a transfer, latch `count[7:0]` and go to HDR_HI.
- **HDR_HI**
  - On a transfer, latch `count[15:8]`.
  - If the full 16-bit count is 0, or greater than `DEPTH`, go to ERR.
  - Otherwise go to DATA.
- **DATA**
  - Each transfer shifts a byte into the assembly register, little-endian: byte k lands in bits [8k+7:8k].
  - On the 4th byte, go to WRITE.
- **WRITE** (exactly one cycle)
  - `we=1`, `wdata` = assembled word, `waddr` = word_idx×4.
  - Then increment word_idx and clear the byte counter.
  - If word_idx+1 == count, go to DONE; else go to DATA.
- **DONE**
  - `done=1`, `cpu_hold=0`.
  - `start` → HDR_LO, which restarts a load and reasserts `cpu_hold` on that edge.
- **ERR**
  - `error=1`, `cpu_hold=1`.
  - `start` → HDR_LO (clears `error`).
- `start` is ignored in HDR_LO, HDR_HI, DATA and WRITE.
- Arithmetic widths:
  - The header count is 16 bits unsigned.
  - word_idx is wide enough to hold `DEPTH`.
  - `waddr` is word_idx zero-extended to `WIDTH`, then shifted left by 2.
  - No wrap-around is possible, because the count is bounded by `DEPTH`.

## Timing
- Reset values (asynchronous, while `rst_n=0`):
  - state=IDLE, `byte_ready=0`, `we=0`, `waddr=0`, `wdata=0`, `cpu_hold=1`, `done=0`, `error=0`.
- `byte_ready` is a registered state decode: 1 in HDR_LO, HDR_HI and DATA; 0 elsewhere.
  - The byte stream must wait out the WRITE cycle.
  - Maximum throughput is 4 bytes per 5 cycles.
- `we`, `waddr` and `wdata` are registered outputs, valid during the WRITE state cycle.
  - `we` is 0 in every other state.
  - `waddr` and `wdata` hold their last value otherwise.
- Latency:
  - The last data byte's transfer edge is followed by one WRITE cycle.
  - DONE is entered on the next edge, so `done` rises and `cpu_hold` falls 2 edges after the last byte.
- Back-to-back `byte_valid` is accepted every cycle in HDR/DATA without bubbles, except the WRITE bubble.
- `byte_valid` low stalls the FSM in its current state with no timeout.
- Mid-operation `rst_n` assertion:
  - Aborts immediately to the reset values.
  - Partial words are never written.
  - Previously written words remain in memory.
- A `start` pulse arriving in the same cycle as `rst_n` deassertion is ignored.

## Test plan
- **Reset values:** assert `rst_n=0` mid-DATA → all outputs at reset values immediately, including `cpu_hold=1`, `we=0` and `byte_ready=0`.
- **Three-word load:**
  - Stimulus: `start`, then bytes 03 00 | 13 00 50 00 | 93 00 A0 00 | 33 81 20 00.
  - Required: exactly 3 `we` pulses with (`waddr`, `wdata`) = (0, 0x00500013), (4, 0x00A00093), (8, 0x00208133).
  - Then `done=1` and `cpu_hold=0` two edges after the last byte.
- **Zero count:** header 00 00 → ERR, `error=1`, `cpu_hold=1`, no `we` pulses, `byte_ready=0`.
- **Over-capacity count:** with `DEPTH=64`, header 41 00 (65) → `error=1`, no writes.
  - Header 40 00 (64) is accepted, and the last write has `waddr`=252.
- **Stalls:** `byte_valid` toggled randomly during the three-word load → identical writes.
  - `byte_ready` must be 0 during each WRITE cycle.
  - No byte is dropped or duplicated.
- **Reload:** `start` in DONE → `cpu_hold` reasserts and `done` clears on the next edge.
  - A second one-word load (01 00 | EF BE AD DE) writes 0xDEADBEEF at `waddr` 0.
  - `start` pulses during DATA are ignored.
